// File: rtl/regfile_writeback_if.sv
// Writeback request channels from the ALU and MEM stages into the regfile write driver.
// Each channel is a valid/ready handshake carrying a destination register and its data.
interface regfile_writeback_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              Alu_Valid;
  logic              Alu_Ready;
  logic [ADDR_W-1:0] Alu_Addr;
  logic [DATA_W-1:0] Alu_Data;
  logic              Mem_Valid;
  logic              Mem_Ready;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Data;

  modport master (
    output Alu_Valid, Alu_Addr, Alu_Data, Mem_Valid, Mem_Addr, Mem_Data,
    input  Alu_Ready, Mem_Ready
  );

  modport slave (
    input  Alu_Valid, Alu_Addr, Alu_Data, Mem_Valid, Mem_Addr, Mem_Data,
    output Alu_Ready, Mem_Ready
  );
endinterface

// File: rtl/regfile_writeback.sv
// Regfile write-side driver: clears all registers after reset, then drains ALU/MEM
// writeback requests through a small FIFO at one write per cycle, with a hazard lookup.
module regfile_writeback #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREGS  = 2**ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst,
  regfile_writeback_if.slave wb,
  output logic [ADDR_W-1:0] Awr,
  output logic [DATA_W-1:0] Din,
  output logic              WrEn,
  output logic              Init_Done,
  input  logic [ADDR_W-1:0] Chk_Addr,
  output logic              Chk_Hit,
  output logic [7:0]        Drop_Cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] qAddr [DEPTH];
  logic [DATA_W-1:0] qData [DEPTH];
  logic [PTR_W-1:0]  wrPtr, rdPtr, memPtr, offs;
  logic [CNT_W-1:0]  count;
  logic              aluReady, memReady;
  logic              aluAcc, memAcc, aluEnq, memEnq, aluDrop, memDrop, deq;
  logic [1:0]        nEnq, nDrop;
  logic [8:0]        dropSum;

  // Readies come only from registered count, so nothing accepted this edge can drain this edge.
  always_comb begin
    aluReady = Init_Done & ~Rst & (count < CNT_W'(DEPTH));
    memReady = Init_Done & ~Rst &
               ((count <= CNT_W'(DEPTH - 2)) | ((count < CNT_W'(DEPTH)) & ~wb.Alu_Valid));
    aluAcc   = wb.Alu_Valid & aluReady;
    memAcc   = wb.Mem_Valid & memReady;
    aluEnq   = aluAcc & (wb.Alu_Addr != '0);
    memEnq   = memAcc & (wb.Mem_Addr != '0);
    aluDrop  = aluAcc & ~aluEnq;
    memDrop  = memAcc & ~memEnq;
    deq      = (state == RUN) & (count != '0);
    nEnq     = {1'b0, aluEnq} + {1'b0, memEnq};
    nDrop    = {1'b0, aluDrop} + {1'b0, memDrop};
    dropSum  = {1'b0, Drop_Cnt} + {7'b0, nDrop};
    memPtr   = aluEnq ? wrPtr + PTR_W'(1) : wrPtr;
  end

  assign wb.Alu_Ready = aluReady;
  assign wb.Mem_Ready = memReady;

  always_ff @(posedge Clk) begin
    if (aluEnq) begin
      qAddr[wrPtr] <= wb.Alu_Addr;
      qData[wrPtr] <= wb.Alu_Data;
    end
    if (memEnq) begin
      qAddr[memPtr] <= wb.Mem_Addr;
      qData[memPtr] <= wb.Mem_Data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= INIT;
      idx       <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      WrEn      <= 1'b0;
      Awr       <= '0;
      Din       <= '0;
      Init_Done <= 1'b0;
      Drop_Cnt  <= '0;
    end else begin
      case (state)
        INIT: begin
          WrEn <= 1'b1;
          Awr  <= idx;
          Din  <= '0;
          idx  <= idx + ADDR_W'(1);
          if (idx == ADDR_W'(NREGS - 1)) state <= RUN;
        end
        RUN: begin
          Init_Done <= 1'b1;
          if (deq) begin
            WrEn  <= 1'b1;
            Awr   <= qAddr[rdPtr];
            Din   <= qData[rdPtr];
            rdPtr <= rdPtr + PTR_W'(1);
          end else begin
            WrEn <= 1'b0;
          end
          wrPtr    <= wrPtr + PTR_W'(nEnq);
          count    <= count + CNT_W'(nEnq) - CNT_W'(deq);
          Drop_Cnt <= (dropSum > 9'd255) ? 8'd255 : dropSum[7:0];
        end
        default: state <= INIT;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    Chk_Hit = 1'b0;
    offs    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rdPtr;
      if ((CNT_W'(offs) < count) && (qAddr[i] == Chk_Addr)) Chk_Hit = 1'b1;
    end
    if (WrEn && (Awr == Chk_Addr)) Chk_Hit = 1'b1;
    Chk_Hit = Chk_Hit & Init_Done & (Chk_Addr != '0);
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus random traffic, every cycle checked
// against a queue-based reference model of the writeback rules.
module tb_regfile_writeback;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Awr;
  logic [31:0] Din;
  logic        WrEn;
  logic        Init_Done;
  logic [4:0]  Chk_Addr;
  logic        Chk_Hit;
  logic [7:0]  Drop_Cnt;

  regfile_writeback_if #(.ADDR_W(5), .DATA_W(32)) wb ();

  regfile_writeback #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32), .NREGS(32)) dut (
    .Clk(clk), .Rst(rst), .wb(wb.slave),
    .Awr(Awr), .Din(Din), .WrEn(WrEn), .Init_Done(Init_Done),
    .Chk_Addr(Chk_Addr), .Chk_Hit(Chk_Hit), .Drop_Cnt(Drop_Cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;

  int          tests = 0;
  int          fails = 0;
  ent_t        q[$];
  bit          mSweep;
  int          mIdx;
  bit          mInitDone;
  bit          mWrEn;
  logic [4:0]  mAwr;
  logic [31:0] mDin;
  int          mDrop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic [4:0] ca);
    int free;
    bit aluR, memR, aluAcc, memAcc, hit;
    ent_t e;
    @(negedge clk);
    rst = r;
    wb.Alu_Valid = av; wb.Alu_Addr = aa; wb.Alu_Data = ad;
    wb.Mem_Valid = mv; wb.Mem_Addr = ma; wb.Mem_Data = md;
    Chk_Addr = ca;
    #1;
    free = DEPTH - q.size();
    aluR = mInitDone && !r && free >= 1;
    memR = mInitDone && !r && (free >= 2 || (free >= 1 && !av));
    chk("aluReady", {31'b0, wb.Alu_Ready}, {31'b0, aluR});
    chk("memReady", {31'b0, wb.Mem_Ready}, {31'b0, memR});
    if (!r) begin
      hit = 0;
      if (ca != 0 && mInitDone) begin
        foreach (q[i]) if (q[i].a == ca) hit = 1;
        if (mWrEn && mAwr == ca) hit = 1;
      end
      chk("chkHit", {31'b0, Chk_Hit}, {31'b0, hit});
    end
    aluAcc = av && aluR;
    memAcc = mv && memR;
    @(posedge clk);
    if (r) begin
      q.delete();
      mSweep = 1; mIdx = 0; mInitDone = 0; mWrEn = 0; mAwr = 0; mDin = 0; mDrop = 0;
    end else if (mSweep) begin
      mWrEn = 1; mAwr = 5'(mIdx); mDin = 0;
      if (mIdx == 31) mSweep = 0;
      mIdx++;
    end else begin
      mInitDone = 1;
      if (q.size() > 0) begin
        e = q.pop_front();
        mWrEn = 1; mAwr = e.a; mDin = e.d;
      end else begin
        mWrEn = 0;
      end
      if (aluAcc) begin
        if (aa == 0) mDrop++; else q.push_back('{a: aa, d: ad});
      end
      if (memAcc) begin
        if (ma == 0) mDrop++; else q.push_back('{a: ma, d: md});
      end
      if (mDrop > 255) mDrop = 255;
    end
    #1;
    chk("wrEn", {31'b0, WrEn}, {31'b0, mWrEn});
    chk("awr", {27'b0, Awr}, {27'b0, mAwr});
    chk("din", Din, mDin);
    chk("initDone", {31'b0, Init_Done}, {31'b0, mInitDone});
    chk("dropCnt", {24'b0, Drop_Cnt}, 32'(mDrop));
  endtask

  task automatic idle(input logic [4:0] ca);
    step(0, 0, 0, 0, 0, 0, 0, ca);
  endtask

  initial begin
    int sweep;
    logic [4:0] a1, a2;
    rst = 1; Chk_Addr = 0;
    wb.Alu_Valid = 0; wb.Alu_Addr = 0; wb.Alu_Data = 0;
    wb.Mem_Valid = 0; wb.Mem_Addr = 0; wb.Mem_Data = 0;
    mSweep = 1; mIdx = 0; mInitDone = 0; mWrEn = 0; mAwr = 0; mDin = 0; mDrop = 0;

    // T1: reset then init sweep
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5'd7, 32'h1, 1, 5'd8, 32'h2, 0);
    sweep = 0;
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 5'd9, 32'h33, 1, 5'd10, 32'h44, 5'(i));
      if (WrEn) sweep++;
    end
    chk("sweepLen", 32'(sweep), 32'd32);
    idle(0);
    chk("initDoneAfterSweep", {31'b0, Init_Done}, 32'd1);

    // T2: single ALU write and hazard lookup
    step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 5'd5);
    for (int i = 0; i < 3; i++) idle(5'd5);

    // T3: paired accept, then fill until full and let it drain
    step(0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 5'd4);
    for (int i = 0; i < 5; i++)
      step(0, 1, 5'(10 + i), $urandom, 1, 5'(20 + i), $urandom, 5'(20 + i));
    for (int i = 0; i < 6; i++) idle(5'(21 + i));

    // T4: leave one free slot and present both requests
    step(0, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hA2, 5'd2);
    step(0, 1, 5'd6, 32'hA3, 1, 5'd7, 32'hA4, 5'd7);
    step(0, 1, 5'd8, 32'hA5, 1, 5'd9, 32'hA6, 5'd9);
    step(0, 0, 0, 0, 1, 5'd9, 32'hA6, 5'd9);
    for (int i = 0; i < 6; i++) idle(5'd9);

    // T5: r0 discards and saturation
    step(0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 5'd0);
    idle(0);
    chk("dropOne", {24'b0, Drop_Cnt}, 32'd1);
    for (int i = 0; i < 150; i++) step(0, 1, 5'd0, $urandom, 1, 5'd0, $urandom, 0);
    idle(0);
    chk("dropSat", {24'b0, Drop_Cnt}, 32'd255);
    step(0, 1, 5'd0, 32'h5, 0, 0, 0, 0);

    // T6: reset with queued entries
    step(0, 1, 5'd11, 32'hC1, 1, 5'd12, 32'hC2, 5'd12);
    step(0, 1, 5'd13, 32'hC3, 1, 5'd14, 32'hC4, 5'd13);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 34; i++) idle(5'd13);

    // random traffic with one mid-run reset
    for (int i = 0; i < 600; i++) begin
      a1 = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      a2 = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      step(i == 300, $urandom_range(0, 9) < 6, a1, $urandom,
           $urandom_range(0, 9) < 6, a2, $urandom, 5'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
